qgen: RTL
=========

# qgen

Quadrature signal generator: the transmit-side counterpart of the quadrature decoder. It accepts move commands (direction, step count, step period) over a valid/ready handshake and emits a Gray-coded I/Q pair, one quadrature edge per step, at a programmable rate. It tracks its own signed position modulo 2^POSW, so a loopback into the decoder can be checked count-for-count. It sits on the CLB-side test and stimulus path, driving encoder inputs or external quadrature lines.

## Interface
- CW, 8: width of step count field.
- DW, 8: width of step-period divider, in clocks.
- POSW, 4: width of position counter; matches the decoder count width.
- clk  in  1  single clock, all logic on posedge.
- clr  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk.
- cmd_dir  in  1  1 = forward (+1 per edge), 0 = reverse (−1 per edge).
- cmd_steps  in  CW  number of quadrature edges to emit; 0 is legal.
- cmd_div  in  DW  clocks per edge; 0 treated as 1.
- abort  in  1  stop the current command after the current edge.
- i  out  1  quadrature channel I, registered.
- q  out  1  quadrature channel Q, registered.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion or abort.
- pos  out  POSW  running position, wraps.

## Operation
- Phase encoding (i,q):
  - Forward sequence: 00→10→11→01→00 (I leads Q).
  - Reverse sequence is the exact inverse.
  - Exactly one of i/q toggles per step.
  - Phase persists between commands.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: cmd_ready=0, busy=1.
  - FIN: cmd_ready=0, busy=0, done=1.
- Transitions:
  - IDLE→RUN on accept. Latch dir, steps, and div (0 is stored as 1), and load timer=div.
  - RUN: decrement timer each cycle. When timer==1:
    - advance phase one step and update pos by ±1;
    - decrement remaining and reload timer.
  - RUN→FIN on the edge that emits the last step, or when remaining==0 at accept.
  - RUN→FIN on abort: the phase does not advance that cycle unless this is a step cycle (the step cycle wins).
  - FIN→IDLE unconditionally.
- Arithmetic:
  - pos wraps modulo 2^POSW: forward from all-ones gives 0, reverse from 0 gives all-ones.
  - The remaining counter is CW bits and never underflows.
- abort is ignored in IDLE and FIN. cmd_valid is ignored outside IDLE.
- clr overrides everything at the next posedge: i=0, q=0, pos=0, busy=0, done=0, state=IDLE, cmd_ready=1. clr aborts a command mid-run with no done pulse.

## Timing
- Accept at edge T0. Step k (1..N) appears on i/q at edge T0+k·div.
- done is high for the cycle after edge T0+N·div (FIN). cmd_ready rises at T0+N·div+1 edge, so the next accept is earliest at T0+N·div+2.
- steps=0: FIN during the cycle after T0, with no I/Q change.
- Abort sampled at edge Ta in RUN: FIN after Ta, and no further edges.
- i, q, pos, busy, and done are all registered. cmd_ready is a decode of state only, with no combinational path from inputs.
- Minimum edge spacing is 1 clock (div=1), giving an I/Q period of 4 clocks.

## Structure
- Shared package qe_pkg:
  - 2-bit phase type and the forward Gray sequence constants (PH0=00, PH1=10, PH2=11, PH3=01);
  - state enum (IDLE, RUN, FIN);
  - default widths, shared with the decoder.
- Sub-module qe_phase: 2-bit phase register plus the step/dir next-phase function, outputting i and q. The top level holds the FSM, timer, remaining counter, and pos.

## Test plan
- Reset: hold clr 2 cycles → i=q=0, pos=0, busy=0, done=0, cmd_ready=1.
- Forward: dir=1, steps=5, div=3 from reset → edges at T0+3,6,9,12,15 with phases 10,11,01,00,10; pos=5; done one cycle after T0+15.
- Reverse and wrap: from pos=0, dir=0, steps=3, div=1 → phases 01,11,10 on consecutive cycles; pos=13 (POSW=4).
- Zero and edge arguments: steps=0 → done after T0, no I/Q toggle. div=0 with steps=2 → edges at T0+1 and T0+2.
- Abort: dir=1, steps=10, div=4, abort pulsed at T0+9 → exactly 2 edges; pos=2; done after T0+9. A back-to-back accept two cycles later succeeds.
- Loopback and reset: run random commands into the decoder and require decoder count == pos after every command. Then assert clr mid-RUN → all outputs return to reset values next cycle with no done pulse.

Source files
------------

// File: rtl/qe_pkg.sv
// Shared quadrature types: Gray phase constants, generator FSM states, default widths.
// Latency: n/a (types, constants and a pure next-phase function only).
// Backpressure: n/a.
package qe_pkg;

   // Default widths, shared with the quadrature decoder so counts line up.
   localparam int QE_CW   = 8;
   localparam int QE_DW   = 8;
   localparam int QE_POSW = 4;

   // Phase is {i,q}. Forward order PH0->PH1->PH2->PH3->PH0 has I leading Q.
   typedef logic [1:0] phase_t;
   localparam phase_t PH0 = 2'b00;
   localparam phase_t PH1 = 2'b10;
   localparam phase_t PH2 = 2'b11;
   localparam phase_t PH3 = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // One Gray step; every transition flips exactly one of i/q.
   function automatic phase_t phase_next(input phase_t ph, input logic fwd);
      phase_t nx;
      case (ph)
         PH0:     nx = fwd ? PH1 : PH3;
         PH1:     nx = fwd ? PH2 : PH0;
         PH2:     nx = fwd ? PH3 : PH1;
         default: nx = fwd ? PH0 : PH2;
      endcase
      return nx;
   endfunction

endpackage

// File: rtl/qe_phase.sv
// Quadrature phase register: advances one Gray step per step pulse in the given direction.
// Latency: i/q change on the clock edge that samples step=1.
// Backpressure: none; step is acted on unconditionally.
// Ports: clk, clr (sync, active-high), step (advance this cycle), dir (1=forward),
//        i/q (registered phase bits).
module qe_phase
   import qe_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic step,
   input  logic dir,
   output logic i,
   output logic q
);

   phase_t ph;

   always_ff @(posedge clk) begin
      if (clr) begin
         ph <= PH0;
      end else if (step) begin
         ph <= phase_next(ph, dir);
      end
   end

   assign i = ph[1];
   assign q = ph[0];

endmodule

// File: rtl/qgen.sv
// Quadrature generator: takes move commands and emits one Gray-coded I/Q edge per step.
// Latency: step k of a command accepted at edge T0 appears at edge T0+k*div.
// Backpressure: cmd_ready is high only in IDLE; commands wait until the previous one has finished.
// Ports: clk, clr (sync, active-high); cmd_valid/cmd_ready handshake with cmd_dir,
//        cmd_steps, cmd_div; abort; outputs i, q, busy, done (1-cycle pulse), pos (wrapping).
module qgen
   import qe_pkg::*;
#(
   parameter int CW   = QE_CW,
   parameter int DW   = QE_DW,
   parameter int POSW = QE_POSW
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_dir,
   input  logic [CW-1:0]   cmd_steps,
   input  logic [DW-1:0]   cmd_div,
   input  logic            abort,
   output logic            i,
   output logic            q,
   output logic            busy,
   output logic            done,
   output logic [POSW-1:0] pos
);

   state_t          state;
   state_t          state_nxt;
   logic            dir_r;
   logic [CW-1:0]   remaining;
   logic [DW-1:0]   div_r;
   logic [DW-1:0]   timer;
   logic [DW-1:0]   div_eff;
   logic            accept;
   logic            step_en;

   // A zero divider would never expire; run it at the fastest legal rate.
   assign div_eff = (cmd_div == '0) ? DW'(1) : cmd_div;

   // Pure state decode: no combinational path from any input.
   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step_en   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               // A zero-length move completes without ever entering RUN.
               state_nxt = (cmd_steps == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (timer == DW'(1)) begin
               step_en = 1'b1;
               if (remaining <= CW'(1)) begin
                  state_nxt = FIN;
               end
            end
            // Abort only stops further edges; a coincident step still goes out.
            if (abort) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         pos       <= '0;
         dir_r     <= 1'b0;
         remaining <= '0;
         div_r     <= DW'(1);
         timer     <= DW'(1);
      end else begin
         // Registered copies of the next-state decode.
         busy <= (state_nxt == RUN);
         done <= (state_nxt == FIN);
         if (accept) begin
            dir_r     <= cmd_dir;
            remaining <= cmd_steps;
            div_r     <= div_eff;
            timer     <= div_eff;
         end else if (state == RUN) begin
            if (step_en) begin
               timer <= div_r;
               if (remaining != '0) begin
                  remaining <= remaining - CW'(1);
               end
               pos <= dir_r ? (pos + POSW'(1)) : (pos - POSW'(1));
            end else begin
               timer <= timer - DW'(1);
            end
         end
      end
   end

   qe_phase u_phase (
      .clk  (clk),
      .clr  (clr),
      .step (step_en),
      .dir  (dir_r),
      .i    (i),
      .q    (q)
   );

endmodule
